// File: rtl/gol_gen_scheduler_pkg.sv
// ============================================================================
// Module  : gol_pkg
// Brief   : Shared state encoding, board width and button indices for the
//           Game of Life generation scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gol_pkg;

    localparam int c_cells     = 256;
    localparam int c_btn_run   = 0;
    localparam int c_btn_step  = 1;
    localparam int c_btn_clear = 2;
    localparam int c_btn_num   = 3;

    typedef enum logic [2:0] {
        ST_SETUP = 3'd0,
        ST_RUN   = 3'd1,
        ST_REQ   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/gol_gen_scheduler_if.sv
// ============================================================================
// Module  : gol_gen_scheduler_if
// Brief   : Step handshake and board bus between scheduler and datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface gol_gen_scheduler_if #(
    parameter int CELLS = 256
);
    logic             step_req_o;
    logic             setup_en_o;
    logic             board_clr_o;
    logic             step_ack_i;
    logic [CELLS-1:0] board_i;

    modport master (output step_req_o, setup_en_o, board_clr_o,
                    input  step_ack_i, board_i);
    modport slave  (input  step_req_o, setup_en_o, board_clr_o,
                    output step_ack_i, board_i);
endinterface

`default_nettype wire

// File: rtl/gol_btn_edge.sv
// ============================================================================
// Module  : gol_btn_edge
// Brief   : One-register rising-edge detector for a debounced button level.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gol_btn_edge (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic level_i,
    output logic      rise_o
);
    logic r_prev;

    // History resets to "pressed" so a level held across reset never
    // looks like a fresh edge once reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= level_i;
        end
    end

    assign rise_o = level_i & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/gol_gen_scheduler.sv
// ============================================================================
// Module  : gol_gen_scheduler
// Brief   : Run-control FSM, step-period divider and generation counter for
//           the 16x16 Game of Life datapath; halts on stable/extinct boards.
//           Optional period-2 oscillator halt: GOL_OSC2_DETECT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gol_gen_scheduler
    import gol_pkg::*;
#(
    parameter int PERIOD_W = 32,
    parameter int GEN_W    = 16,
    parameter int CELLS    = c_cells
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                run_btn_i,
    input  wire logic                step_btn_i,
    input  wire logic                clear_btn_i,
    input  wire logic [PERIOD_W-1:0] period_i,
    gol_gen_scheduler_if.master      bus,
    output logic [2:0]               state_o,
    output logic [GEN_W-1:0]         generation_cnt_o,
    output logic                     stable_o,
`ifdef GOL_OSC2_DETECT_EN
    output logic                     osc2_o,
`endif
    output logic                     extinct_o
);

    logic [c_btn_num-1:0] w_lvl;
    logic [c_btn_num-1:0] w_ev;
    logic                 w_clr, w_run, w_step;

    assign w_lvl[c_btn_run]   = run_btn_i;
    assign w_lvl[c_btn_step]  = step_btn_i;
    assign w_lvl[c_btn_clear] = clear_btn_i;

    for (genvar gi = 0; gi < c_btn_num; gi++) begin : g_btn
        gol_btn_edge u_edge (
            .clk     (clk),
            .reset   (reset),
            .level_i (w_lvl[gi]),
            .rise_o  (w_ev[gi])
        );
    end

    assign w_clr  = w_ev[c_btn_clear];
    assign w_run  = w_ev[c_btn_run]  & ~w_clr;
    assign w_step = w_ev[c_btn_step] & ~w_clr & ~w_ev[c_btn_run];

    state_t               r_state, w_state_next;
    logic                 r_step_req, r_setup_en, r_board_clr;
    logic [GEN_W-1:0]     r_cnt, w_cnt_next;
    logic                 r_stable, w_stable_next, r_extinct, w_extinct_next;
    logic [PERIOD_W-1:0]  r_div, w_div_next, w_period_m1;
    logic                 r_ret_run, w_ret_next;
    logic                 w_snap_load;
    logic [CELLS-1:0]     r_snap;
    logic                 w_same, w_zero;
`ifdef GOL_OSC2_DETECT_EN
    logic [CELLS-1:0]     r_snap2;
    logic                 r_osc2, w_osc2_next;
`endif

    assign w_period_m1 = (period_i == '0) ? '0 : period_i - 1'b1;
    assign w_same      = (bus.board_i == r_snap);
    assign w_zero      = (bus.board_i == '0);

    always_comb begin
        w_state_next   = r_state;
        w_div_next     = r_div;
        w_ret_next     = r_ret_run;
        w_cnt_next     = r_cnt;
        w_stable_next  = r_stable;
        w_extinct_next = r_extinct;
        w_snap_load    = 1'b0;
`ifdef GOL_OSC2_DETECT_EN
        w_osc2_next    = r_osc2;
`endif
        if (w_clr) begin
            w_state_next   = ST_SETUP;
            w_cnt_next     = '0;
            w_stable_next  = 1'b0;
            w_extinct_next = 1'b0;
`ifdef GOL_OSC2_DETECT_EN
            w_osc2_next    = 1'b0;
`endif
        end else begin
            case (r_state)
                ST_SETUP: begin
                    if (w_run) begin
                        w_state_next = ST_RUN;
                        w_div_next   = '0;
                        w_snap_load  = 1'b1;
                    end else if (w_step) begin
                        w_state_next = ST_REQ;
                        w_ret_next   = 1'b0;
                        w_snap_load  = 1'b1;
                    end
                end
                ST_RUN: begin
                    // >= so a period shrunk below the divider fires at once
                    if (w_run) begin
                        w_state_next = ST_PAUSE;
                    end else if (r_div >= w_period_m1) begin
                        w_div_next   = '0;
                        w_state_next = ST_REQ;
                        w_ret_next   = 1'b1;
                    end else begin
                        w_div_next   = r_div + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (w_run) begin
                        w_state_next = ST_RUN;
                    end else if (w_step) begin
                        w_state_next = ST_REQ;
                        w_ret_next   = 1'b0;
                    end
                end
                ST_REQ: begin
                    if (w_run) begin
                        w_ret_next = 1'b0;
                    end
                    if (bus.step_ack_i) begin
                        if (&r_cnt) begin
                            w_state_next = ST_HALT;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                            if (w_same || w_zero) begin
                                w_state_next   = ST_HALT;
                                w_stable_next  = w_same;
                                w_extinct_next = w_zero;
`ifdef GOL_OSC2_DETECT_EN
                            end else if (bus.board_i == r_snap2) begin
                                w_state_next = ST_HALT;
                                w_osc2_next  = 1'b1;
`endif
                            end else begin
                                w_state_next = w_ret_next ? ST_RUN : ST_PAUSE;
                                w_snap_load  = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_SETUP;
            r_step_req  <= 1'b0;
            r_setup_en  <= 1'b1;
            r_board_clr <= 1'b0;
            r_cnt       <= '0;
            r_stable    <= 1'b0;
            r_extinct   <= 1'b0;
            r_div       <= '0;
            r_ret_run   <= 1'b0;
            r_snap      <= '0;
`ifdef GOL_OSC2_DETECT_EN
            r_snap2     <= '0;
            r_osc2      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_step_req  <= (w_state_next == ST_REQ);
            r_setup_en  <= (w_state_next == ST_SETUP);
            r_board_clr <= w_clr;
            r_cnt       <= w_cnt_next;
            r_stable    <= w_stable_next;
            r_extinct   <= w_extinct_next;
            r_div       <= w_div_next;
            r_ret_run   <= w_ret_next;
            if (w_snap_load) begin
                r_snap  <= bus.board_i;
`ifdef GOL_OSC2_DETECT_EN
                r_snap2 <= (r_state == ST_SETUP) ? bus.board_i : r_snap;
`endif
            end
`ifdef GOL_OSC2_DETECT_EN
            r_osc2      <= w_osc2_next;
`endif
        end
    end

    assign state_o          = r_state;
    assign generation_cnt_o = r_cnt;
    assign stable_o         = r_stable;
    assign extinct_o        = r_extinct;
    assign bus.step_req_o   = r_step_req;
    assign bus.setup_en_o   = r_setup_en;
    assign bus.board_clr_o  = r_board_clr;
`ifdef GOL_OSC2_DETECT_EN
    assign osc2_o           = r_osc2;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gol_gen_scheduler.sv
// ============================================================================
// Module  : tb_gol_gen_scheduler
// Brief   : Directed-plus-random bench for gol_gen_scheduler (GEN_W=4 build).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gol_gen_scheduler;

    localparam int GEN_W = 4;
    localparam int S_SETUP = 0, S_RUN = 1, S_REQ = 2, S_PAUSE = 3, S_HALT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_btn, step_btn, clear_btn;
    logic [31:0] period;
    logic [2:0]  state;
    logic [GEN_W-1:0] gen_cnt;
    logic        stable, extinct;
`ifdef GOL_OSC2_DETECT_EN
    logic        osc2;
`endif

    gol_gen_scheduler_if #(.CELLS(256)) bus ();

    gol_gen_scheduler #(.PERIOD_W(32), .GEN_W(GEN_W), .CELLS(256)) dut (
        .clk              (clk),
        .reset            (reset),
        .run_btn_i        (run_btn),
        .step_btn_i       (step_btn),
        .clear_btn_i      (clear_btn),
        .period_i         (period),
        .bus              (bus),
        .state_o          (state),
        .generation_cnt_o (gen_cnt),
        .stable_o         (stable),
`ifdef GOL_OSC2_DETECT_EN
        .osc2_o           (osc2),
`endif
        .extinct_o        (extinct)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Transaction-level model: snapshot, generation count, return target.
    logic [255:0] m_snap;
    int           m_cnt;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_board();
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [255:0] fresh_board();
        logic [255:0] b;
        b = rand_board();
        while (b == '0 || b == m_snap) b = rand_board();
        return b;
    endfunction

    task automatic press_run();
        run_btn = 1'b1; tick(); run_btn = 1'b0;
    endtask

    task automatic press_step();
        step_btn = 1'b1; tick(); step_btn = 1'b0;
    endtask

    task automatic press_clear();
        clear_btn = 1'b1; tick(); clear_btn = 1'b0;
    endtask

    // Returns cycles until step_req_o seen high; a blown budget counts as a failure.
    task automatic wait_req(input string tag, output int n);
        n = 0;
        while (bus.step_req_o !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, (n < 64), 1'b1);
    endtask

    // Present a new board with a one-cycle ack and check the predicted outcome.
    task automatic do_ack(input string tag, input logic [255:0] nb, input int ret_state);
        int  exp_state;
        logic exp_st, exp_ex;
        exp_st = 1'b0;
        exp_ex = 1'b0;
        if (m_cnt == (1 << GEN_W) - 1) begin
            exp_state = S_HALT;
        end else begin
            m_cnt++;
            exp_st = (nb == m_snap);
            exp_ex = (nb == '0);
            if (exp_st || exp_ex) begin
                exp_state = S_HALT;
            end else begin
                exp_state = ret_state;
                m_snap    = nb;
            end
        end
        bus.board_i = nb;
        bus.step_ack_i = 1'b1;
        tick();
        bus.step_ack_i = 1'b0;
        check({tag, "_state"},   state, exp_state);
        check({tag, "_cnt"},     gen_cnt, m_cnt);
        check({tag, "_req"},     bus.step_req_o, 1'b0);
        check({tag, "_stable"},  stable, exp_st);
        check({tag, "_extinct"}, extinct, exp_ex);
    endtask

    initial begin
        logic [255:0] blinker, blinker_v, block;
        int n;

        blinker = '0; blinker_v = '0; block = '0;
        blinker[5*16+4] = 1'b1; blinker[5*16+5] = 1'b1; blinker[5*16+6] = 1'b1;
        blinker_v[4*16+5] = 1'b1; blinker_v[5*16+5] = 1'b1; blinker_v[6*16+5] = 1'b1;
        block[8*16+8] = 1'b1; block[8*16+9] = 1'b1; block[9*16+8] = 1'b1; block[9*16+9] = 1'b1;

        reset = 1'b1; run_btn = 1'b1; step_btn = 1'b0; clear_btn = 1'b0;
        period = 32'd4; bus.step_ack_i = 1'b0; bus.board_i = rand_board();
        m_snap = '0; m_cnt = 0;

        // Reset with run held: no event afterwards.
        tick(); tick(); tick();
        check("rst_state", state, S_SETUP);
        check("rst_setup_en", bus.setup_en_o, 1'b1);
        check("rst_req", bus.step_req_o, 1'b0);
        check("rst_clr", bus.board_clr_o, 1'b0);
        check("rst_cnt", gen_cnt, 0);
        reset = 1'b0;
        tick(); tick();
        check("held_run_no_event", state, S_SETUP);
        run_btn = 1'b0;
        tick();

        // SETUP -> RUN, period 4: request four cycles after RUN entry.
        bus.board_i = fresh_board();
        m_snap = bus.board_i;
        press_run();
        check("run_entry", state, S_RUN);
        check("run_setup_en", bus.setup_en_o, 1'b0);
        wait_req("req1", n);
        check("period4_latency", n, 4);
        check("req_state", state, S_REQ);
        do_ack("ack_run", fresh_board(), S_RUN);

        // Pause, then single-step a blinker with a slow ack.
        press_run();
        check("pause", state, S_PAUSE);
        bus.board_i = blinker;
        press_step();
        check("step_req", bus.step_req_o, 1'b1);
        tick(); tick();
        check("req_held", bus.step_req_o, 1'b1);
        do_ack("blinker", blinker_v, S_PAUSE);

        // Run with a 2x2 block until it is seen twice in a row: stable halt.
        press_run();
        check("resume", state, S_RUN);
        wait_req("req_blk1", n);
        do_ack("block1", block, S_RUN);
        wait_req("req_blk2", n);
        do_ack("block2", block, S_RUN);
        press_run();
        press_step();
        check("halt_sticky", state, S_HALT);
        check("halt_no_req", bus.step_req_o, 1'b0);
        press_clear();
        m_cnt = 0;
        check("clr_state", state, S_SETUP);
        check("clr_pulse", bus.board_clr_o, 1'b1);
        check("clr_cnt", gen_cnt, 0);
        check("clr_stable", stable, 1'b0);
        tick();
        check("clr_pulse_end", bus.board_clr_o, 1'b0);

        // Extinction from a random board.
        bus.board_i = fresh_board();
        m_snap = bus.board_i;
        press_run();
        wait_req("req_ext", n);
        do_ack("extinct", '0, S_RUN);
        press_clear();
        m_cnt = 0;
        check("clr2_extinct", extinct, 1'b0);

        // Simultaneous clear+run+step while running: clear only.
        bus.board_i = fresh_board();
        m_snap = bus.board_i;
        press_run();
        run_btn = 1'b1; step_btn = 1'b1; clear_btn = 1'b1;
        tick();
        run_btn = 1'b0; step_btn = 1'b0; clear_btn = 1'b0;
        check("combo_state", state, S_SETUP);
        check("combo_clr", bus.board_clr_o, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        check("combo_no_req", bus.step_req_o, 1'b0);
        check("combo_stay", state, S_SETUP);

        // Period 0 acts as 1; saturate the 4-bit counter with random boards.
        period = 32'd0;
        bus.board_i = fresh_board();
        m_snap = bus.board_i;
        press_run();
        wait_req("req_p0", n);
        check("period0_latency", n, 1);
        for (int g = 0; g < 15; g++) begin
            if (g > 0) wait_req("req_sat", n);
            do_ack("sat_step", fresh_board(), S_RUN);
        end
        check("sat_cnt15", gen_cnt, 15);
        wait_req("req_ovf", n);
        do_ack("overflow", fresh_board(), S_RUN);
        check("ovf_halt", state, S_HALT);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
